riscv_dmem_ctrl: RTL

RISCV_DMEM_CTRL -- requirements
Module: riscv_dmem_ctrl

---
 rtl/riscv_dmem_ctrl_pkg.sv | 18 +
 rtl/riscv_bram.sv | 35 +++
 rtl/riscv_dmem_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_ctrl_pkg.sv
// Shared types for the byte-serial data-memory controller: access-size selector
// and controller state encoding.
package riscv_dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    MASK_B = 2'd0,
    MASK_H = 2'd1,
    MASK_X = 2'd2
  } mask_sel_e;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_DRAIN  = 2'd2,
    DMEM_RESP   = 2'd3
  } dmem_ctrl_state_e;

endpackage

// File: rtl/riscv_bram.sv
// Byte-wide synchronous BRAM with independent read/write addresses and a
// one-cycle registered read.
module riscv_bram #(
  parameter int ADDR_LENGTH = 32,
  parameter int NUM_MEM     = 16384
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [ADDR_LENGTH-1:0] i_waddr,
  input  logic [7:0]             i_wdata,
  input  logic [ADDR_LENGTH-1:0] i_raddr,
  output logic [7:0]             o_rdata
);

  localparam int IDX_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;

  logic [7:0] r_mem [NUM_MEM];
  logic [7:0] r_rdata;
  logic       w_wr_in_range;
  logic       w_rd_in_range;

  // Out-of-range addresses are dropped on write and read back as zero.
  assign w_wr_in_range = ({1'b0, i_waddr} < (ADDR_LENGTH+1)'(NUM_MEM));
  assign w_rd_in_range = ({1'b0, i_raddr} < (ADDR_LENGTH+1)'(NUM_MEM));

  always_ff @(posedge clk) begin
    if (i_we && w_wr_in_range) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
    r_rdata <= w_rd_in_range ? r_mem[i_raddr[IDX_W-1:0]] : '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: serialises byte/half/word loads and stores onto a
// byte-wide BRAM, one byte per cycle, with range checking and load extension.
module riscv_dmem_ctrl
  import riscv_dmem_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int NUM_MEM     = 16384
) (
  input  logic                   clk,
  input  logic                   x_reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic                   req_write,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  logic [1:0]             req_mask,
  input  logic                   req_unsigned,
  output logic                   rsp_valid,
  output logic [WORD_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err
);

  localparam int unsigned BYTE_LANES = WORD_LENGTH / 8;
  localparam int unsigned CW         = $clog2(BYTE_LANES) + 1;
  localparam int unsigned HALF_N     = (BYTE_LANES < 2) ? BYTE_LANES : 2;

  dmem_ctrl_state_e r_state, w_state_nxt;

  logic [ADDR_LENGTH-1:0] r_addr;
  logic                   r_write;
  logic [WORD_LENGTH-1:0] r_wdata;
  logic                   r_unsigned;
  logic [CW-1:0]          r_n;
  logic [CW-1:0]          r_k;
  logic [WORD_LENGTH-1:0] r_acc;
  logic [WORD_LENGTH-1:0] r_rsp_rdata;
  logic                   r_rsp_err;

  logic [CW-1:0]          w_n;
  logic [ADDR_LENGTH:0]   w_end;
  logic                   w_err;
  logic                   w_accept;
  logic [ADDR_LENGTH-1:0] w_mem_addr;
  logic                   w_mem_we;
  logic [7:0]             w_wbyte;
  logic [7:0]             w_rbyte;
  logic [WORD_LENGTH-1:0] w_merged;
  logic                   w_sign;
  logic [WORD_LENGTH-1:0] w_ext;

  always_comb begin
    w_n = CW'(BYTE_LANES);
    case (mask_sel_e'(req_mask))
      MASK_B:  w_n = CW'(1);
      MASK_H:  w_n = CW'(HALF_N);
      default: w_n = CW'(BYTE_LANES);
    endcase
  end

  // One extra bit so an address near the top of the space cannot wrap into range.
  assign w_end    = {1'b0, req_addr} + (ADDR_LENGTH+1)'(w_n);
  assign w_err    = (w_end > (ADDR_LENGTH+1)'(NUM_MEM));
  assign w_accept = req_valid && (r_state == DMEM_IDLE) && !x_reset;

  assign w_mem_addr = r_addr + ADDR_LENGTH'(r_k);
  assign w_mem_we   = (r_state == DMEM_ACCESS) && r_write && !x_reset;

  always_comb begin
    w_wbyte = '0;
    for (int unsigned i = 0; i < BYTE_LANES; i++) begin
      if (r_k == CW'(i)) w_wbyte = r_wdata[8*i +: 8];
    end
  end

  // Read data returned now belongs to the byte issued last cycle, lane k-1.
  always_comb begin
    w_merged = r_acc;
    for (int unsigned i = 0; i < BYTE_LANES; i++) begin
      if (r_k == CW'(i + 1)) w_merged[8*i +: 8] = w_rbyte;
    end
  end

  always_comb begin
    w_sign = 1'b0;
    for (int unsigned i = 0; i < BYTE_LANES; i++) begin
      if (r_n == CW'(i + 1)) w_sign = w_merged[8*i + 7];
    end
  end

  always_comb begin
    w_ext = '0;
    for (int unsigned i = 0; i < BYTE_LANES; i++) begin
      w_ext[8*i +: 8] = (CW'(i) < r_n) ? w_merged[8*i +: 8]
                                       : {8{w_sign & ~r_unsigned}};
    end
  end

  riscv_bram #(
    .ADDR_LENGTH (ADDR_LENGTH),
    .NUM_MEM     (NUM_MEM)
  ) u_bram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_addr),
    .i_wdata (w_wbyte),
    .i_raddr (w_mem_addr),
    .o_rdata (w_rbyte)
  );

  always_ff @(posedge clk) begin
    if (x_reset) r_state <= DMEM_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DMEM_IDLE: begin
        if (w_accept) w_state_nxt = w_err ? DMEM_RESP : DMEM_ACCESS;
      end
      DMEM_ACCESS: begin
        if (r_k == r_n - CW'(1)) w_state_nxt = DMEM_DRAIN;
      end
      DMEM_DRAIN: w_state_nxt = DMEM_RESP;
      DMEM_RESP:  w_state_nxt = DMEM_IDLE;
      default:    w_state_nxt = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_reset) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_unsigned  <= 1'b0;
      r_n         <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        DMEM_IDLE: begin
          if (w_accept) begin
            r_addr     <= req_addr;
            r_write    <= req_write;
            r_wdata    <= req_wdata;
            r_unsigned <= req_unsigned;
            r_n        <= w_n;
            r_k        <= '0;
            r_acc      <= '0;
            if (w_err) begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        DMEM_ACCESS: begin
          r_k   <= r_k + CW'(1);
          r_acc <= w_merged;
        end
        DMEM_DRAIN: begin
          r_acc       <= w_merged;
          r_rsp_rdata <= r_write ? '0 : w_ext;
          r_rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == DMEM_IDLE);
  assign rsp_valid = (r_state == DMEM_RESP) && !x_reset;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
